// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator for raster-order RGB444 video.
// Two line buffers supply rows y-1/y-2; each window appears two cycles after its newest pixel is accepted.
module pixel_window_3x3 #(
  parameter int LINE_WIDTH = 640,
  parameter int PIX_W      = 12
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixelIn,
  input  logic             pixelValid,
  input  logic             frameStart,
  output logic [PIX_W-1:0] outPixel_lu,
  output logic [PIX_W-1:0] outPixel_lm,
  output logic [PIX_W-1:0] outPixel_ld,
  output logic [PIX_W-1:0] outPixel_mu,
  output logic [PIX_W-1:0] outPixel_mm,
  output logic [PIX_W-1:0] outPixel_md,
  output logic [PIX_W-1:0] outPixel_ru,
  output logic [PIX_W-1:0] outPixel_rm,
  output logic [PIX_W-1:0] outPixel_rd,
  output logic             windowValid,
  output logic [9:0]       outXAddr,
  output logic [9:0]       outYAddr
);

  localparam int         AW       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [9:0] LAST_COL = 10'(LINE_WIDTH - 1);

  logic             w_accept;
  logic [9:0]       w_col;
  logic [9:0]       w_row;
  logic [AW-1:0]    w_addr;
  logic             w_win_ok;

  logic [9:0]       r_col;
  logic [9:0]       r_row;
  logic [PIX_W-1:0] r_lb0 [LINE_WIDTH];
  logic [PIX_W-1:0] r_lb1 [LINE_WIDTH];

  logic             r_vld_p1;
  logic [PIX_W-1:0] r_pix_p1;
  logic [9:0]       r_col_p1;
  logic [9:0]       r_row_p1;
  logic [PIX_W-1:0] r_lb0_q_p1;
  logic [PIX_W-1:0] r_lb1_q_p1;

  logic [PIX_W-1:0] r_win_mu_p2;
  logic [PIX_W-1:0] r_win_mm_p2;
  logic [PIX_W-1:0] r_win_md_p2;
  logic [PIX_W-1:0] r_win_ru_p2;
  logic [PIX_W-1:0] r_win_rm_p2;
  logic [PIX_W-1:0] r_win_rd_p2;

  // reset outranks a simultaneous pixel, so a dropped pixel touches neither RAM nor pipeline
  assign w_accept = pixelValid & ~reset;
  assign w_col    = frameStart ? 10'd0 : r_col;
  assign w_row    = frameStart ? 10'd0 : r_row;
  assign w_addr   = w_col[AW-1:0];

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pixelValid) begin
      if (w_col == LAST_COL) begin
        r_col <= '0;
        r_row <= w_row + 10'd1;
      end else begin
        r_col <= w_col + 10'd1;
        r_row <= w_row;
      end
    end
  end

  // ---- stage 1: accept, read-before-write line buffers ----
  always_ff @(posedge clk25) begin
    if (w_accept) begin
      r_lb0_q_p1    <= r_lb0[w_addr];
      r_lb1_q_p1    <= r_lb1[w_addr];
      r_lb1[w_addr] <= r_lb0[w_addr];
      r_lb0[w_addr] <= pixelIn;
    end
  end

  always_ff @(posedge clk25) begin
    if (w_accept) begin
      r_pix_p1 <= pixelIn;
      r_col_p1 <= w_col;
      r_row_p1 <= w_row;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= pixelValid;
  end

  // ---- stage 2: column shift and qualified output load ----
  assign w_win_ok = r_vld_p1 && (r_col_p1 >= 10'd2) && (r_row_p1 >= 10'd2);

  always_ff @(posedge clk25) begin
    if (r_vld_p1) begin
      r_win_mu_p2 <= r_win_ru_p2;
      r_win_mm_p2 <= r_win_rm_p2;
      r_win_md_p2 <= r_win_rd_p2;
      r_win_ru_p2 <= r_lb1_q_p1;
      r_win_rm_p2 <= r_lb0_q_p1;
      r_win_rd_p2 <= r_pix_p1;
    end
  end

  // outputs take the post-shift window directly so they can hold across border pixels
  always_ff @(posedge clk25) begin
    if (reset) begin
      windowValid <= 1'b0;
      outPixel_lu <= '0;
      outPixel_lm <= '0;
      outPixel_ld <= '0;
      outPixel_mu <= '0;
      outPixel_mm <= '0;
      outPixel_md <= '0;
      outPixel_ru <= '0;
      outPixel_rm <= '0;
      outPixel_rd <= '0;
      outXAddr    <= '0;
      outYAddr    <= '0;
    end else begin
      windowValid <= w_win_ok;
      if (w_win_ok) begin
        outPixel_lu <= r_win_mu_p2;
        outPixel_lm <= r_win_mm_p2;
        outPixel_ld <= r_win_md_p2;
        outPixel_mu <= r_win_ru_p2;
        outPixel_mm <= r_win_rm_p2;
        outPixel_md <= r_win_rd_p2;
        outPixel_ru <= r_lb1_q_p1;
        outPixel_rm <= r_lb0_q_p1;
        outPixel_rd <= r_pix_p1;
        outXAddr    <= r_col_p1 - 10'd1;
        outYAddr    <= r_row_p1 - 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Bench for pixel_window_3x3: an 8-pixel-line instance for directed scenarios and a 640-pixel-line
// instance for random streaming, both scored against a frame-image window model.
module tb_pixel_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    int           due;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [107:0] taps;
  } exp_t;

  // ---------------- DUT A: LINE_WIDTH = 8 ----------------
  logic        a_rst, a_vld, a_fs;
  logic [11:0] a_pix;
  logic [11:0] a_lu, a_lm, a_ld, a_mu, a_mm, a_md, a_ru, a_rm, a_rd;
  logic        a_wv;
  logic [9:0]  a_x, a_y;

  pixel_window_3x3 #(.LINE_WIDTH(8), .PIX_W(12)) u_dut_a (
    .clk25(clk), .reset(a_rst), .pixelIn(a_pix), .pixelValid(a_vld), .frameStart(a_fs),
    .outPixel_lu(a_lu), .outPixel_lm(a_lm), .outPixel_ld(a_ld),
    .outPixel_mu(a_mu), .outPixel_mm(a_mm), .outPixel_md(a_md),
    .outPixel_ru(a_ru), .outPixel_rm(a_rm), .outPixel_rd(a_rd),
    .windowValid(a_wv), .outXAddr(a_x), .outYAddr(a_y)
  );

  // ---------------- DUT B: LINE_WIDTH = 640 ----------------
  logic        b_rst, b_vld, b_fs;
  logic [11:0] b_pix;
  logic [11:0] b_lu, b_lm, b_ld, b_mu, b_mm, b_md, b_ru, b_rm, b_rd;
  logic        b_wv;
  logic [9:0]  b_x, b_y;

  pixel_window_3x3 #(.LINE_WIDTH(640), .PIX_W(12)) u_dut_b (
    .clk25(clk), .reset(b_rst), .pixelIn(b_pix), .pixelValid(b_vld), .frameStart(b_fs),
    .outPixel_lu(b_lu), .outPixel_lm(b_lm), .outPixel_ld(b_ld),
    .outPixel_mu(b_mu), .outPixel_mm(b_mm), .outPixel_md(b_md),
    .outPixel_ru(b_ru), .outPixel_rm(b_rm), .outPixel_rd(b_rd),
    .windowValid(b_wv), .outXAddr(b_x), .outYAddr(b_y)
  );

  // ---------------- reference model: frame image + expected-window queues ----------------
  int          ma_col = 0, ma_row = 0;
  int          mb_col = 0, mb_row = 0;
  logic [11:0] imga [16][8];
  logic [11:0] imgb [16][640];
  exp_t        qa[$];
  exp_t        qb[$];
  logic [55:0] a_log[$];   // {x, y, mm, lu, rd} per observed window
  int          cont_base = 0;

  task automatic drive_a(input logic [11:0] pix, input logic vld, input logic fs, input logic rst);
    exp_t e;
    int   x, y;
    @(negedge clk);
    a_pix = pix; a_vld = vld; a_fs = fs; a_rst = rst;
    if (rst) begin
      while (qa.size() != 0 && qa[$].due > cyc) void'(qa.pop_back());
      ma_col = 0; ma_row = 0;
    end else if (vld) begin
      if (fs) begin ma_col = 0; ma_row = 0; end
      x = ma_col; y = ma_row;
      imga[y % 16][x] = pix;
      if (x >= 2 && y >= 2) begin
        e.due  = cyc + 2;
        e.x    = 10'(x - 1);
        e.y    = 10'(y - 1);
        e.taps = {imga[(y-2)%16][x-2], imga[(y-1)%16][x-2], imga[y%16][x-2],
                  imga[(y-2)%16][x-1], imga[(y-1)%16][x-1], imga[y%16][x-1],
                  imga[(y-2)%16][x],   imga[(y-1)%16][x],   imga[y%16][x]};
        qa.push_back(e);
      end
      ma_col = (x == 7) ? 0 : x + 1;
      ma_row = (x == 7) ? (y + 1) % 1024 : y;
    end
  endtask

  task automatic drive_b(input logic [11:0] pix, input logic vld, input logic fs);
    exp_t e;
    int   x, y;
    @(negedge clk);
    b_pix = pix; b_vld = vld; b_fs = fs; b_rst = 1'b0;
    if (vld) begin
      if (fs) begin mb_col = 0; mb_row = 0; end
      x = mb_col; y = mb_row;
      imgb[y % 16][x] = pix;
      if (x >= 2 && y >= 2) begin
        e.due  = cyc + 2;
        e.x    = 10'(x - 1);
        e.y    = 10'(y - 1);
        e.taps = {imgb[(y-2)%16][x-2], imgb[(y-1)%16][x-2], imgb[y%16][x-2],
                  imgb[(y-2)%16][x-1], imgb[(y-1)%16][x-1], imgb[y%16][x-1],
                  imgb[(y-2)%16][x],   imgb[(y-1)%16][x],   imgb[y%16][x]};
        qb.push_back(e);
      end
      mb_col = (x == 639) ? 0 : x + 1;
      mb_row = (x == 639) ? (y + 1) % 1024 : y;
    end
  endtask

  // ---------------- output monitors ----------------
  logic         a_rst_s = 1'b0, b_rst_s = 1'b0;
  logic [107:0] a_last_taps = '0, b_last_taps = '0;
  logic [9:0]   a_last_x = '0, a_last_y = '0, b_last_x = '0, b_last_y = '0;
  exp_t         a_e, b_e;
  int           b_npulse = 0;
  wire  [107:0] a_taps = {a_lu, a_lm, a_ld, a_mu, a_mm, a_md, a_ru, a_rm, a_rd};
  wire  [107:0] b_taps = {b_lu, b_lm, b_ld, b_mu, b_mm, b_md, b_ru, b_rm, b_rd};

  always @(posedge clk) begin
    a_rst_s <= a_rst;
    b_rst_s <= b_rst;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (a_rst_s) begin
        checks++;
        if ({a_wv, a_x, a_y, a_taps} !== '0) begin
          errors++;
          $display("FAIL a_reset_outputs got wv=%b x=%0d y=%0d taps=%h want all zero", a_wv, a_x, a_y, a_taps);
        end
        a_last_taps = '0; a_last_x = '0; a_last_y = '0;
      end else if (a_wv === 1'b1) begin
        a_log.push_back({a_x, a_y, a_mm, a_lu, a_rd});
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_window got x=%0d y=%0d want no window", a_x, a_y);
        end else begin
          a_e = qa.pop_front();
          if (a_e.due != cyc || a_x !== a_e.x || a_y !== a_e.y) begin
            errors++;
            $display("FAIL a_window_addr got cyc=%0d x=%0d y=%0d want cyc=%0d x=%0d y=%0d",
                     cyc, a_x, a_y, a_e.due, a_e.x, a_e.y);
          end
          checks++;
          if (a_taps !== a_e.taps) begin
            errors++;
            $display("FAIL a_window_taps got %h want %h", a_taps, a_e.taps);
          end
        end
        a_last_taps = a_taps; a_last_x = a_x; a_last_y = a_y;
      end else begin
        checks++;
        if (a_wv !== 1'b0 || a_taps !== a_last_taps || a_x !== a_last_x || a_y !== a_last_y) begin
          errors++;
          $display("FAIL a_hold got wv=%b x=%0d y=%0d taps=%h want wv=0 x=%0d y=%0d taps=%h",
                   a_wv, a_x, a_y, a_taps, a_last_x, a_last_y, a_last_taps);
        end
        if (qa.size() != 0 && qa[0].due <= cyc) begin
          a_e = qa.pop_front();
          errors++;
          $display("FAIL a_missing_window got none want x=%0d y=%0d at cyc=%0d", a_e.x, a_e.y, a_e.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_rst_s) begin
        checks++;
        if ({b_wv, b_x, b_y, b_taps} !== '0) begin
          errors++;
          $display("FAIL b_reset_outputs got wv=%b x=%0d y=%0d want all zero", b_wv, b_x, b_y);
        end
        b_last_taps = '0; b_last_x = '0; b_last_y = '0;
      end else if (b_wv === 1'b1) begin
        b_npulse++;
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_window got x=%0d y=%0d want no window", b_x, b_y);
        end else begin
          b_e = qb.pop_front();
          if (b_e.due != cyc || b_x !== b_e.x || b_y !== b_e.y || b_taps !== b_e.taps) begin
            errors++;
            $display("FAIL b_window got cyc=%0d x=%0d y=%0d taps=%h want cyc=%0d x=%0d y=%0d taps=%h",
                     cyc, b_x, b_y, b_taps, b_e.due, b_e.x, b_e.y, b_e.taps);
          end
        end
        b_last_taps = b_taps; b_last_x = b_x; b_last_y = b_y;
      end else begin
        checks++;
        if (b_wv !== 1'b0 || b_taps !== b_last_taps || b_x !== b_last_x || b_y !== b_last_y) begin
          errors++;
          $display("FAIL b_hold got wv=%b x=%0d y=%0d want wv=0 x=%0d y=%0d", b_wv, b_x, b_y, b_last_x, b_last_y);
        end
        if (qb.size() != 0 && qb[0].due <= cyc) begin
          b_e = qb.pop_front();
          errors++;
          $display("FAIL b_missing_window got none want x=%0d y=%0d at cyc=%0d", b_e.x, b_e.y, b_e.due);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic stream_a(input int npix, input int gaps, input bit fs_first, input bit pattern);
    logic [11:0] pix;
    for (int i = 0; i < npix; i++) begin
      pix = pattern ? {4'(i / 8), 4'(i % 8), 4'h5} : 12'($urandom);
      drive_a(pix, 1'b1, fs_first && (i == 0), 1'b0);
      for (int g = 0; g < gaps; g++) drive_a(12'($urandom), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(12'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_wv, a_x, a_y, a_taps, b_wv, b_x, b_y, b_taps} !== '0) begin
      errors++;
      $display("FAIL reset_state got a_wv=%b a_x=%0d a_y=%0d b_wv=%b b_x=%0d b_y=%0d want all zero",
               a_wv, a_x, a_y, b_wv, b_x, b_y);
    end
    mon_en = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
  endtask

  task automatic test_continuous();
    int          n;
    logic [55:0] f;
    cont_base = a_log.size();
    stream_a(48, 0, 1'b1, 1'b1);
    idle_a(3);
    n = a_log.size() - cont_base;
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL cont_pulse_count got %0d want 24", n);
    end else begin
      f = a_log[cont_base];
      checks++;
      if (f !== {10'd1, 10'd1, 12'h115, 12'h005, 12'h225}) begin
        errors++;
        $display("FAIL cont_first_window got x=%0d y=%0d mm=%h lu=%h rd=%h want x=1 y=1 mm=115 lu=005 rd=225",
                 f[55:46], f[45:36], f[35:24], f[23:12], f[11:0]);
      end
      for (int k = 0; k < 24; k++) begin
        f = a_log[cont_base + k];
        checks++;
        if (f[55:46] !== 10'(k % 6 + 1) || f[45:36] !== 10'(k / 6 + 1)) begin
          errors++;
          $display("FAIL cont_addr_seq got x=%0d y=%0d want x=%0d y=%0d", f[55:46], f[45:36], k % 6 + 1, k / 6 + 1);
        end
      end
    end
  endtask

  task automatic test_idle_gaps();
    int base, n;
    base = a_log.size();
    stream_a(48, 3, 1'b1, 1'b1);
    idle_a(3);
    n = a_log.size() - base;
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL gaps_pulse_count got %0d want 24", n);
    end else begin
      for (int k = 0; k < 24; k++) begin
        checks++;
        if (a_log[base + k] !== a_log[cont_base + k]) begin
          errors++;
          $display("FAIL gaps_vs_continuous got %h want %h", a_log[base + k], a_log[cont_base + k]);
        end
      end
    end
  endtask

  task automatic test_frame_start_mid();
    int base, n;
    stream_a(28, 0, 1'b1, 1'b1);
    base = a_log.size();
    stream_a(32, 0, 1'b1, 1'b1);
    idle_a(3);
    n = a_log.size() - base;
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL fsmid_pulse_count got %0d want 14", n);
    end else begin
      checks++;
      if (a_log[base][55:36] !== {10'd1, 10'd2} || a_log[base + 1][55:36] !== {10'd2, 10'd2} ||
          a_log[base + 2][55:36] !== {10'd1, 10'd1}) begin
        errors++;
        $display("FAIL fsmid_addrs got (%0d,%0d) (%0d,%0d) (%0d,%0d) want (1,2) (2,2) (1,1)",
                 a_log[base][55:46], a_log[base][45:36], a_log[base+1][55:46], a_log[base+1][45:36],
                 a_log[base+2][55:46], a_log[base+2][45:36]);
      end
    end
  endtask

  task automatic test_reset_mid(input bit fs_restart);
    int base, n;
    stream_a(35, 0, 1'b1, fs_restart);
    drive_a({4'h4, 4'h3, 4'h5}, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({a_wv, a_x, a_y, a_taps} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got wv=%b x=%0d y=%0d taps=%h want all zero", a_wv, a_x, a_y, a_taps);
    end
    base = a_log.size();
    stream_a(32, 0, fs_restart, 1'b0);
    idle_a(3);
    n = a_log.size() - base;
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL rstmid_pulse_count got %0d want 12", n);
    end else begin
      checks++;
      if (a_log[base][55:36] !== {10'd1, 10'd1}) begin
        errors++;
        $display("FAIL rstmid_first_addr got x=%0d y=%0d want x=1 y=1", a_log[base][55:46], a_log[base][45:36]);
      end
    end
  endtask

  task automatic test_random_640();
    int base;
    base = b_npulse;
    for (int i = 0; i < 640 * 8; i++) begin
      drive_b(12'($urandom), 1'b1, i == 0);
      if ($urandom_range(0, 7) == 0) drive_b(12'($urandom), 1'b0, 1'b0);
    end
    repeat (3) drive_b(12'd0, 1'b0, 1'b0);
    checks++;
    if (b_npulse - base != 638 * 6) begin
      errors++;
      $display("FAIL rand640_pulse_count got %0d want %0d", b_npulse - base, 638 * 6);
    end
    checks++;
    if (b_last_x !== 10'd638 || b_last_y !== 10'd6) begin
      errors++;
      $display("FAIL rand640_last_addr got x=%0d y=%0d want x=638 y=6", b_last_x, b_last_y);
    end
  endtask

  initial begin
    a_rst = 1'b1; a_vld = 1'b0; a_fs = 1'b0; a_pix = '0;
    b_rst = 1'b1; b_vld = 1'b0; b_fs = 1'b0; b_pix = '0;
    test_reset();
    test_continuous();
    test_idle_gaps();
    test_frame_start_mid();
    test_reset_mid(1'b1);
    test_reset_mid(1'b0);
    test_random_640();
    idle_a(4);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_windows got a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
